// File: rtl/eth_stream_arbiter.sv
// eth_stream_arbiter
//
// Round-robin arbiter that merges the per-channel AXI-to-stream sources
// (AW, W, B, AR, R) into one AXI4-Stream master feeding the Ethernet framer.
// One source is granted at a time and the grant is held for the whole packet.
// Accepted beats go through a 2-entry output FIFO whose head drives m_axis_*.
//
// Optional feature (macro ETH_STREAM_ARB_HEADER_EN):
//   Each grant first pushes a header beat {zero pad, seq[15:0], grant index}
//   (extra HDR state). A timeout release after a header pushes one
//   zero-data padding beat with tlast=1 so downstream framing stays closed.
//   When the macro is undefined there is no HDR state and no seq counter.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-high reset
//   src_valid        per-source beat available
//   src_in_progress  per-source: packet continues after the current beat
//   src_data         per-source beat, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready        per-source ready, at most one bit set
//   m_axis_tdata     output beat
//   m_axis_tvalid    output beat valid
//   m_axis_tready    downstream ready
//   m_axis_tlast     last beat of packet
//   m_axis_tuser     index of the source that produced the beat

module eth_stream_arbiter #(
   parameter int NUM_SRC      = 5,
   parameter int DATA_WIDTH   = 128,
   parameter int SRC_ID_WIDTH = 3,
   parameter int IDLE_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC-1:0]            src_in_progress,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [SRC_ID_WIDTH-1:0]       m_axis_tuser
);

   localparam int FIFO_W = DATA_WIDTH + 1 + SRC_ID_WIDTH;

`ifdef ETH_STREAM_ARB_HEADER_EN
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, HDR = 2'd2} state_t;
`else
   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;
`endif

   state_t                  state_q, state_d;
   logic [SRC_ID_WIDTH-1:0] grant_q, grant_d;
   logic [SRC_ID_WIDTH-1:0] ptr_q, ptr_d;
   logic [15:0]             idle_cnt_q, idle_cnt_d;
`ifdef ETH_STREAM_ARB_HEADER_EN
   logic [15:0]             seq_q, seq_d;
`endif

   logic [FIFO_W-1:0]       fifo_mem [2];
   logic                    wr_ptr_q, rd_ptr_q;
   logic [1:0]              count_q;

   logic                    fifo_space;
   logic                    pop;
   logic                    push;
   logic [DATA_WIDTH-1:0]   push_data;
   logic                    push_last;
   logic [SRC_ID_WIDTH-1:0] push_user;

   logic                    sel_valid;
   logic                    sel_inprog;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    accept;

   logic                    found;
   logic [SRC_ID_WIDTH-1:0] pick;
   logic [SRC_ID_WIDTH-1:0] cand;

   // Ready depends only on registered state, so there is no combinational
   // path from m_axis_tready to src_ready.
   assign fifo_space = (count_q != 2'd2);
   assign pop        = (count_q != 2'd0) && m_axis_tready;

   assign sel_valid  = src_valid[grant_q];
   assign sel_inprog = src_in_progress[grant_q];
   assign sel_data   = src_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
   assign accept     = (state_q == GRANT) && fifo_space && sel_valid;

   always_comb begin
      src_ready = '0;
      if ((state_q == GRANT) && fifo_space) begin
         src_ready[grant_q] = 1'b1;
      end
   end

   // Round-robin search: first requesting source after ptr, with wrap.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = ptr_q;
      for (int i = 1; i <= NUM_SRC; i++) begin
         cand = SRC_ID_WIDTH'((int'(ptr_q) + i) % NUM_SRC);
         if (!found && src_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      idle_cnt_d = idle_cnt_q;
      push       = 1'b0;
      push_data  = '0;
      push_last  = 1'b0;
      push_user  = grant_q;
`ifdef ETH_STREAM_ARB_HEADER_EN
      seq_d      = seq_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d    = pick;
               idle_cnt_d = '0;
`ifdef ETH_STREAM_ARB_HEADER_EN
               state_d    = HDR;
`else
               state_d    = GRANT;
`endif
            end
         end
`ifdef ETH_STREAM_ARB_HEADER_EN
         HDR: begin
            if (fifo_space) begin
               push                                = 1'b1;
               push_data[SRC_ID_WIDTH-1:0]         = grant_q;
               push_data[SRC_ID_WIDTH +: 16]       = seq_q;
               seq_d                               = seq_q + 16'd1;
               state_d                             = GRANT;
            end
         end
`endif
         GRANT: begin
            if (accept) begin
               push       = 1'b1;
               push_data  = sel_data;
               push_last  = !sel_inprog;
               idle_cnt_d = '0;
               if (!sel_inprog) begin
                  ptr_d   = grant_q;
                  state_d = IDLE;
               end
            end else if (!sel_inprog) begin
               if (idle_cnt_q == 16'(IDLE_TIMEOUT - 1)) begin
`ifdef ETH_STREAM_ARB_HEADER_EN
                  // The header already opened a frame; close it with a pad
                  // beat, waiting for FIFO space if necessary.
                  if (fifo_space) begin
                     push      = 1'b1;
                     push_last = 1'b1;
                     ptr_d     = grant_q;
                     state_d   = IDLE;
                  end
`else
                  ptr_d   = grant_q;
                  state_d = IDLE;
`endif
               end else begin
                  idle_cnt_d = idle_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ptr_q       <= SRC_ID_WIDTH'(NUM_SRC - 1);
         idle_cnt_q  <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
`ifdef ETH_STREAM_ARB_HEADER_EN
         seq_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         idle_cnt_q <= idle_cnt_d;
`ifdef ETH_STREAM_ARB_HEADER_EN
         seq_q      <= seq_d;
`endif
         if (push) begin
            fifo_mem[wr_ptr_q] <= {push_data, push_last, push_user};
            wr_ptr_q           <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (push && !pop) begin
            count_q <= count_q + 2'd1;
         end else if (!push && pop) begin
            count_q <= count_q - 2'd1;
         end
      end
   end

   // FIFO head drives the stream outputs.
   assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = fifo_mem[rd_ptr_q];
   assign m_axis_tvalid = (count_q != 2'd0);

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Testbench for eth_stream_arbiter: per-source beat queues model the
// stream sources; every accepted beat is pushed to a scoreboard and compared
// when it leaves m_axis.

module tb_eth_stream_arbiter;

   localparam int NS = 5;
   localparam int DW = 32;
   localparam int IW = 3;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [NS-1:0]   src_valid;
   logic [NS-1:0]   src_in_progress;
   logic [NS*DW-1:0] src_data;
   logic [NS-1:0]   src_ready;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic            m_axis_tlast;
   logic [IW-1:0]   m_axis_tuser;

   eth_stream_arbiter #(
      .NUM_SRC      (NS),
      .DATA_WIDTH   (DW),
      .SRC_ID_WIDTH (IW),
      .IDLE_TIMEOUT (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .src_valid       (src_valid),
      .src_in_progress (src_in_progress),
      .src_data        (src_data),
      .src_ready       (src_ready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tuser    (m_axis_tuser)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [IW-1:0] user;
   } exp_t;

   beat_t       srcq [NS][$];
   exp_t        sb[$];
   logic [IW:0] out_log[$];
   bit          auto_mode = 1'b0;
   int          total = 0;
   int          bad   = 0;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int pending_beats();
      int n = 0;
      for (int i = 0; i < NS; i++) n += srcq[i].size();
      return n;
   endfunction

   // Source model and output monitor.
   initial begin : model
      logic [NS-1:0] hs;
      exp_t          e;
      beat_t         b;
      forever begin
         @(negedge clk);
         if (m_axis_tvalid && m_axis_tready) begin
            out_log.push_back({m_axis_tlast, m_axis_tuser});
            chk_eq("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk_eq("tdata", 64'(m_axis_tdata), 64'(e.data));
               chk_eq("tlast", 64'(m_axis_tlast), 64'(e.last));
               chk_eq("tuser", 64'(m_axis_tuser), 64'(e.user));
            end
         end
         chk_eq("ready_onehot", 64'($countones(src_ready) <= 1), 64'd1);
         hs = auto_mode ? (src_ready & src_valid) : '0;
         for (int i = 0; i < NS; i++) begin
            if (hs[i] && srcq[i].size() > 0) begin
               e.data = srcq[i][0].data;
               e.last = srcq[i][0].last;
               e.user = IW'(i);
               sb.push_back(e);
            end
         end
         @(posedge clk);
         #1;
         if (auto_mode) begin
            for (int i = 0; i < NS; i++) begin
               if (hs[i] && srcq[i].size() > 0) b = srcq[i].pop_front();
               if (srcq[i].size() > 0) begin
                  src_valid[i]             = 1'b1;
                  src_in_progress[i]       = !srcq[i][0].last;
                  src_data[i*DW +: DW]     = srcq[i][0].data;
               end else begin
                  src_valid[i]             = 1'b0;
                  src_in_progress[i]       = 1'b0;
                  src_data[i*DW +: DW]     = '0;
               end
            end
         end
      end
   end

   task automatic apply_reset();
      auto_mode       = 1'b0;
      src_valid       = '0;
      src_in_progress = '0;
      src_data        = '0;
      reset           = 1'b1;
      sb.delete();
      for (int i = 0; i < NS; i++) srcq[i].delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      out_log.delete();
   endtask

   task automatic push_beat(input int s, input logic [DW-1:0] d, input logic last);
      beat_t b;
      b.data = d;
      b.last = last;
      srcq[s].push_back(b);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((sb.size() != 0 || pending_beats() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk_eq(tag, 64'(sb.size() + pending_beats()), 64'd0);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int n;
      reset           = 1'b1;
      src_valid       = '1;
      src_in_progress = '0;
      src_data        = '0;
      m_axis_tready   = 1'b1;

      // Reset held with every source requesting.
      repeat (3) begin
         @(negedge clk);
         chk_eq("rst_ready",  64'(src_ready),     64'd0);
         chk_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
         chk_eq("rst_tdata",  64'(m_axis_tdata),  64'd0);
         chk_eq("rst_tlast",  64'(m_axis_tlast),  64'd0);
      end
      reset = 1'b0;
      @(negedge clk);
      chk_eq("first_grant_src0", 64'(src_ready), 64'b00001);
      src_valid = '0;
      @(negedge clk);

      // Single-beat packet from source 2.
      apply_reset();
      auto_mode = 1'b1;
      push_beat(2, 32'hA5, 1'b1);
      @(negedge clk);
      chk_eq("sb_ready_before_grant", 64'(src_ready), 64'd0);
      @(negedge clk);
      chk_eq("sb_ready_granted", 64'(src_ready), 64'b00100);
      @(negedge clk);
      chk_eq("sb_out_valid", 64'(m_axis_tvalid), 64'd1);
      chk_eq("sb_out_data",  64'(m_axis_tdata),  64'hA5);
      chk_eq("sb_out_last",  64'(m_axis_tlast),  64'd1);
      chk_eq("sb_out_user",  64'(m_axis_tuser),  64'd2);
      chk_eq("sb_ready_drop", 64'(src_ready), 64'd0);
      wait_drain("sb_drain");

      // Round robin: every source offers two single-beat packets.
      apply_reset();
      auto_mode = 1'b1;
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < NS; s++)
            push_beat(s, DW'(32'h100 * s + p), 1'b1);
      wait_drain("rr_drain");
      chk_eq("rr_count", 64'(out_log.size()), 64'd10);
      for (int k = 0; k < out_log.size(); k++)
         chk_eq("rr_order", 64'(out_log[k][IW-1:0]), 64'(k % NS));

      // Backpressure: 4-beat packet from source 1 with tready low.
      apply_reset();
      m_axis_tready = 1'b0;
      auto_mode = 1'b1;
      for (int k = 0; k < 4; k++) push_beat(1, DW'(32'h10 + k), k == 3);
      repeat (10) @(negedge clk);
      chk_eq("bp_buffered",   64'(sb.size()),        64'd2);
      chk_eq("bp_src_left",   64'(srcq[1].size()),   64'd2);
      chk_eq("bp_ready_low",  64'(src_ready),        64'd0);
      chk_eq("bp_tvalid",     64'(m_axis_tvalid),    64'd1);
      chk_eq("bp_head_data",  64'(m_axis_tdata),     64'h10);
      out_log.delete();
      m_axis_tready = 1'b1;
      wait_drain("bp_drain");
      chk_eq("bp_out_count", 64'(out_log.size()), 64'd4);
      for (int k = 0; k < out_log.size(); k++) begin
         chk_eq("bp_tlast_pos", 64'(out_log[k][IW]), 64'(k == 3));
         chk_eq("bp_tuser",     64'(out_log[k][IW-1:0]), 64'd1);
      end

      // Idle timeout: source 3 granted then withdraws; source 4 waits.
      apply_reset();
      src_valid = 5'b01000;
      @(negedge clk);
      chk_eq("to_grant3", 64'(src_ready), 64'b01000);
      src_valid = 5'b10000;
      for (int k = 0; k < TO - 1; k++) begin
         @(negedge clk);
         chk_eq("to_hold", 64'(src_ready), 64'b01000);
         chk_eq("to_no_out", 64'(m_axis_tvalid), 64'd0);
      end
      @(negedge clk);
      chk_eq("to_released", 64'(src_ready), 64'd0);
      @(negedge clk);
      chk_eq("to_next_src4", 64'(src_ready), 64'b10000);
      chk_eq("to_no_out_end", 64'(m_axis_tvalid), 64'd0);
      src_valid = '0;
      @(negedge clk);

      // Reset in the middle of a 5-beat packet.
      apply_reset();
      m_axis_tready = 1'b0;
      auto_mode = 1'b1;
      for (int k = 0; k < 5; k++) push_beat(0, DW'(32'h50 + k), k == 4);
      n = 0;
      while (sb.size() < 2 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk_eq("mid_two_accepted", 64'(sb.size()), 64'd2);
      @(negedge clk);
      chk_eq("mid_fifo_busy", 64'(m_axis_tvalid), 64'd1);
      auto_mode       = 1'b0;
      src_valid       = '0;
      src_in_progress = '0;
      reset           = 1'b1;
      sb.delete();
      for (int i = 0; i < NS; i++) srcq[i].delete();
      @(negedge clk);
      chk_eq("mid_tvalid_cleared", 64'(m_axis_tvalid), 64'd0);
      chk_eq("mid_tlast_cleared",  64'(m_axis_tlast),  64'd0);
      chk_eq("mid_ready_cleared",  64'(src_ready),     64'd0);
      reset = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(negedge clk);
      chk_eq("mid_stays_empty", 64'(m_axis_tvalid), 64'd0);

      // Recovery after the truncated packet.
      auto_mode = 1'b1;
      push_beat(4, 32'hBEEF, 1'b1);
      wait_drain("rec_drain");
      chk_eq("rec_count", 64'(out_log.size()), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
